// File: rtl/ms_slave_accumulator_pkg.sv
// Shared types for the master-slave accumulator: section encoding and
// saturation limits at the default sample width.
package ms_slave_accumulator_types;

  typedef enum logic [1:0] {
    SECTION_IDLE   = 2'd0,
    SECTION_SAMPLE = 2'd1,
    SECTION_SEND   = 2'd2
  } section_t;

  localparam int DATA_W_DEFAULT = 32;

  localparam logic [DATA_W_DEFAULT-1:0] SAT_MAX = {1'b0, {(DATA_W_DEFAULT-1){1'b1}}};
  localparam logic [DATA_W_DEFAULT-1:0] SAT_MIN = {1'b1, {(DATA_W_DEFAULT-1){1'b0}}};

endpackage

// File: rtl/ms_slave_accumulator_sat_add.sv
// Combinational two's-complement saturating adder; clamp flags a result
// that was pinned to the most positive or most negative value.
module sat_add #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum,
  output logic              clamp
);

  logic [DATA_W:0] wide_sum;

  // One guard bit: overflow shows as the top two bits disagreeing.
  assign wide_sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};
  assign clamp    = wide_sum[DATA_W] ^ wide_sum[DATA_W-1];

  always_comb begin
    sum = wide_sum[DATA_W-1:0];
    if (clamp) begin
      sum = wide_sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                             : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/ms_slave_accumulator.sv
// Slave-side consumer: sums NUM_SAMPLES master-slave samples with saturation
// and offers the result on a notify/sync port. MS_SLAVE_ACC_DROP_CNT_EN adds drop_cnt.
module ms_slave_accumulator
  import ms_slave_accumulator_types::*;
#(
  parameter int NUM_SAMPLES = 4,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_in,
  output logic [DATA_W-1:0] b_out_sig,
  output logic              b_out_notify,
  input  logic              b_out_sync,
  output logic              sat_flag
`ifdef MS_SLAVE_ACC_DROP_CNT_EN
  ,
  output logic [15:0]       drop_cnt
`endif
);

  localparam int CNT_W = $clog2(NUM_SAMPLES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SAMPLES - 1);

  section_t          section_reg;
  logic [DATA_W-1:0] sum_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              sat_seen_reg;
  logic [DATA_W-1:0] sum_next;
  logic              clamp_now;

  sat_add #(.DATA_W(DATA_W)) u_sat_add (
    .a     (sum_reg),
    .b     (s_in),
    .sum   (sum_next),
    .clamp (clamp_now)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      section_reg  <= SECTION_IDLE;
      sum_reg      <= '0;
      count_reg    <= '0;
      sat_seen_reg <= 1'b0;
      b_out_sig    <= '0;
      b_out_notify <= 1'b0;
      sat_flag     <= 1'b0;
    end else begin
      case (section_reg)
        SECTION_IDLE: section_reg <= SECTION_SAMPLE;
        SECTION_SAMPLE: begin
          if (count_reg == LAST_CNT) begin
            b_out_sig    <= sum_next;
            sat_flag     <= sat_seen_reg | clamp_now;
            b_out_notify <= 1'b1;
            section_reg  <= SECTION_SEND;
          end else begin
            sum_reg      <= sum_next;
            count_reg    <= count_reg + CNT_W'(1);
            sat_seen_reg <= sat_seen_reg | clamp_now;
          end
        end
        SECTION_SEND: begin
          // Samples seen here are dropped; the window restarts empty.
          if (b_out_sync) begin
            b_out_notify <= 1'b0;
            sum_reg      <= '0;
            count_reg    <= '0;
            sat_seen_reg <= 1'b0;
            section_reg  <= SECTION_SAMPLE;
          end
        end
        default: section_reg <= SECTION_IDLE;
      endcase
    end
  end

`ifdef MS_SLAVE_ACC_DROP_CNT_EN
  // Lifetime stall counter; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (section_reg == SECTION_SEND && drop_cnt != 16'hFFFF) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`else
  // No stall counter in this build.
`endif

endmodule

// File: tb/tb_ms_slave_accumulator.sv
// Self-checking bench: directed vector tables for NUM_SAMPLES=4 and 1, then
// randomized traffic against a queue-based window model.
module tb_ms_slave_accumulator;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, sync, notify, sat;
  logic [31:0] s_in, sig;
  logic        rst1, sync1, notify1, sat1;
  logic [31:0] s_in1, sig1;
`ifdef MS_SLAVE_ACC_DROP_CNT_EN
  logic [15:0] drop, drop1;
`endif

  int vectors = 0;
  int miscompares = 0;

  ms_slave_accumulator #(.NUM_SAMPLES(4), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .s_in(s_in), .b_out_sig(sig),
    .b_out_notify(notify), .b_out_sync(sync), .sat_flag(sat)
`ifdef MS_SLAVE_ACC_DROP_CNT_EN
    , .drop_cnt(drop)
`endif
  );

  ms_slave_accumulator #(.NUM_SAMPLES(1), .DATA_W(32)) dut1 (
    .clk(clk), .rst(rst1), .s_in(s_in1), .b_out_sig(sig1),
    .b_out_notify(notify1), .b_out_sync(sync1), .sat_flag(sat1)
`ifdef MS_SLAVE_ACC_DROP_CNT_EN
    , .drop_cnt(drop1)
`endif
  );

  typedef struct {
    logic        r;
    logic        sy;
    logic [31:0] s;
    logic        n;
    logic [31:0] sg;
    logic        st;
  } vec_t;

  vec_t tbl[$];
  vec_t tbl1[$];

  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic r, input logic sy, input logic [31:0] s,
                              input logic n, input logic [31:0] sg, input logic st);
    vec_t v;
    v.r = r; v.sy = sy; v.s = s; v.n = n; v.sg = sg; v.st = st;
    return v;
  endfunction

  // Saturating running sum of one window, clamping after every addition.
  function automatic void window_sum(input int q[$], output logic [31:0] sum, output logic sat_o);
    longint acc;
    acc = 0;
    sat_o = 1'b0;
    foreach (q[i]) begin
      acc = acc + longint'(q[i]);
      if (acc > MAXV) begin acc = MAXV; sat_o = 1'b1; end
      else if (acc < MINV) begin acc = MINV; sat_o = 1'b1; end
    end
    sum = acc[31:0];
  endfunction

  initial begin
    int          phase;
    int          q[$];
    logic        e_n, e_sat, r, sy;
    logic [31:0] e_sig, s;
    logic [15:0] e_drop;

    rst = 1'b1; sync = 1'b0; s_in = '0;
    rst1 = 1'b1; sync1 = 1'b1; s_in1 = '0;

    // NUM_SAMPLES=4 directed table: inputs for one edge, outputs just after it.
    tbl.push_back(mk(1, 0, 32'd0,  0, 32'd0,  0));
    tbl.push_back(mk(0, 0, 32'd99, 0, 32'd0,  0));
    tbl.push_back(mk(0, 1, 32'd1,  0, 32'd0,  0));
    tbl.push_back(mk(0, 1, 32'd2,  0, 32'd0,  0));
    tbl.push_back(mk(0, 1, 32'd3,  0, 32'd0,  0));
    tbl.push_back(mk(0, 1, 32'd4,  1, 32'd10, 0));
    tbl.push_back(mk(0, 1, 32'd50, 0, 32'd10, 0));
    tbl.push_back(mk(0, 1, 32'h7FFFFFF0, 0, 32'd10, 0));
    tbl.push_back(mk(0, 1, 32'h20, 0, 32'd10, 0));
    tbl.push_back(mk(0, 1, 32'd5,  0, 32'd10, 0));
    tbl.push_back(mk(0, 1, 32'd5,  1, 32'h7FFFFFFF, 1));
    tbl.push_back(mk(0, 1, 32'd123, 0, 32'h7FFFFFFF, 1));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 1, 32'hFFFFFFFF, 0, 32'h7FFFFFFF, 1));
    tbl.push_back(mk(0, 1, 32'hFFFFFFFF, 1, 32'hFFFFFFFC, 0));
    tbl.push_back(mk(0, 1, 32'd0,  0, 32'hFFFFFFFC, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 32'd7, 0, 32'hFFFFFFFC, 0));
    tbl.push_back(mk(0, 0, 32'd7,  1, 32'd28, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 0, 32'd1000, 1, 32'd28, 0));
    tbl.push_back(mk(0, 1, 32'd1000, 0, 32'd28, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 32'd1, 0, 32'd28, 0));
    tbl.push_back(mk(0, 0, 32'd1,  1, 32'd4, 0));
    tbl.push_back(mk(1, 0, 32'd1,  0, 32'd0, 0));
    tbl.push_back(mk(0, 1, 32'd9,  0, 32'd0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 1, 32'd2, 0, 32'd0, 0));
    tbl.push_back(mk(0, 1, 32'd2,  1, 32'd8, 0));
    tbl.push_back(mk(0, 1, 32'd0,  0, 32'd8, 0));
    tbl.push_back(mk(0, 0, 32'h80000000, 0, 32'd8, 0));
    tbl.push_back(mk(0, 0, 32'hFFFFFFFF, 0, 32'd8, 0));
    tbl.push_back(mk(0, 0, 32'd0,  0, 32'd8, 0));
    tbl.push_back(mk(0, 0, 32'd0,  1, 32'h80000000, 1));
    tbl.push_back(mk(0, 1, 32'd0,  0, 32'h80000000, 1));

    foreach (tbl[i]) begin
      rst = tbl[i].r; sync = tbl[i].sy; s_in = tbl[i].s;
      step();
      $display("vec %0d: rst=%b sync=%b s_in=%h -> notify=%b sig=%h sat=%b",
               i, tbl[i].r, tbl[i].sy, tbl[i].s, notify, sig, sat);
      chk($sformatf("n4_notify[%0d]", i), {31'd0, notify}, {31'd0, tbl[i].n});
      chk($sformatf("n4_sig[%0d]", i), sig, tbl[i].sg);
      chk($sformatf("n4_sat[%0d]", i), {31'd0, sat}, {31'd0, tbl[i].st});
    end

    // NUM_SAMPLES=1: every other sample is dropped in the handshake cycle.
    tbl1.push_back(mk(1, 1, 32'd0, 0, 32'd0, 0));
    tbl1.push_back(mk(0, 1, 32'd4, 0, 32'd0, 0));
    tbl1.push_back(mk(0, 1, 32'd5, 1, 32'd5, 0));
    tbl1.push_back(mk(0, 1, 32'd6, 0, 32'd5, 0));
    tbl1.push_back(mk(0, 1, 32'd7, 1, 32'd7, 0));
    tbl1.push_back(mk(0, 1, 32'd8, 0, 32'd7, 0));
    tbl1.push_back(mk(0, 1, 32'd9, 1, 32'd9, 0));
    foreach (tbl1[i]) begin
      rst1 = tbl1[i].r; sync1 = tbl1[i].sy; s_in1 = tbl1[i].s;
      step();
      $display("vec1 %0d: s_in=%h -> notify=%b sig=%h", i, tbl1[i].s, notify1, sig1);
      chk($sformatf("n1_notify[%0d]", i), {31'd0, notify1}, {31'd0, tbl1[i].n});
      chk($sformatf("n1_sig[%0d]", i), sig1, tbl1[i].sg);
      chk($sformatf("n1_sat[%0d]", i), {31'd0, sat1}, {31'd0, tbl1[i].st});
    end
    rst1 = 1'b1;

    // Randomized traffic against a window-level model.
    phase = 0; e_n = 0; e_sig = '0; e_sat = 0; e_drop = '0;
    for (int i = 0; i < 3000; i++) begin
      r  = (i == 0) || ($urandom_range(0, 199) == 0);
      sy = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 3))
        0: s = $urandom;
        1: s = $urandom_range(0, 200) - 32'd100;
        2: s = 32'h7FFF0000 + $urandom_range(0, 65535);
        default: s = 32'h80000000 + $urandom_range(0, 65535);
      endcase
      if (r) begin
        phase = 0; q.delete(); e_n = 0; e_sig = '0; e_sat = 0; e_drop = '0;
      end else begin
        if (phase == 2 && e_drop != 16'hFFFF) e_drop = e_drop + 16'd1;
        case (phase)
          0: phase = 1;
          1: begin
            q.push_back(int'(s));
            if (q.size() == 4) begin
              window_sum(q, e_sig, e_sat);
              e_n = 1; phase = 2; q.delete();
            end
          end
          default: if (sy) begin
            $display("xfer cycle %0d: sum=%h sat=%b", i, e_sig, e_sat);
            e_n = 0; phase = 1;
          end
        endcase
      end
      rst = r; sync = sy; s_in = s;
      step();
      chk($sformatf("rnd_notify[%0d]", i), {31'd0, notify}, {31'd0, e_n});
      chk($sformatf("rnd_sig[%0d]", i), sig, e_sig);
      chk($sformatf("rnd_sat[%0d]", i), {31'd0, sat}, {31'd0, e_sat});
`ifdef MS_SLAVE_ACC_DROP_CNT_EN
      chk($sformatf("rnd_drop[%0d]", i), {16'd0, drop}, {16'd0, e_drop});
`endif
    end

`ifdef MS_SLAVE_ACC_DROP_CNT_EN
    // Three stall cycles plus the handshake cycle, then a very long stall.
    rst = 1'b1; sync = 1'b0; s_in = 32'd3; step();
    rst = 1'b0; step();
    for (int i = 0; i < 4; i++) step();
    for (int i = 0; i < 3; i++) step();
    sync = 1'b1; step();
    chk("drop_after_stall", {16'd0, drop}, 32'd4);
    sync = 1'b0;
    for (int i = 0; i < 4; i++) step();
    for (int i = 0; i < 70000; i++) step();
    chk("drop_saturated", {16'd0, drop}, 32'h0000FFFF);
    chk("notify_long_stall", {31'd0, notify}, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ms_slave_accumulator.md
Name: ms_slave_accumulator

Overview:
- Downstream consumer of the master-slave integer output (s_out) of the section-based test master.
- Samples that non-blocking master-slave value every cycle while in its sampling section.
- Forms a signed saturating sum over NUM_SAMPLES samples.
- Publishes the sum on a blocking notify/sync output port.
- Slave side of the master-slave pair in the DeSCAM PrintSkeleton test set; gives the generated skeleton a real consumer to check against.

Parameters:
- NUM_SAMPLES, 4: samples per accumulation window; legal range 1..65535.
- DATA_W, 32: width of the integer sample and sum (two's complement).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- s_in  input  DATA_W  master-slave sample, valid every cycle, no handshake.
- b_out_sig  output  DATA_W  accumulated sum.
- b_out_notify  output  1  b_out_sig valid (blocking-port request).
- b_out_sync  input  1  consumer ready; transfer on cycle where notify && sync.
- sat_flag  output  1  window just sent contained at least one saturation.

Interface: one clock; reset is synchronous and active-high (clk, rst). The section enum and constants live in the package.

Behaviour:
- Reset (rst high at a clk edge):
  - section_signal <= SECTION_IDLE; sum, count <= 0.
  - b_out_sig <= 0; b_out_notify <= 0; sat_flag <= 0.
  - Reset mid-window or mid-send aborts the window. A pending notify drops the following cycle; no transfer occurs.
- SECTION_IDLE: one cycle after reset release, then goes to SECTION_SAMPLE. s_in is ignored.
- SECTION_SAMPLE, each cycle:
  - sum_next = sat(sum + s_in), computed in DATA_W+1 bits.
  - Clamp to +2^(DATA_W-1)-1 or -2^(DATA_W-1) on overflow; set the internal sat_seen bit on clamp.
  - count increments.
- Window complete, in the cycle where count == NUM_SAMPLES-1:
  - b_out_sig <= sum_next; sat_flag <= sat_seen | clamp_this_cycle; b_out_notify <= 1.
  - Go to SECTION_SEND.
  - Latency: last sample at edge k gives notify high after edge k.
- NUM_SAMPLES = 1: every sampled cycle completes a window.
- SECTION_SEND:
  - b_out_sig, sat_flag and notify are held stable until an edge with b_out_sync = 1.
  - On that edge: notify <= 0; sum, count, sat_seen <= 0; go to SECTION_SAMPLE.
  - Samples arriving during SEND (including the handshake cycle) are discarded, never buffered.
- b_out_sync outside SEND has no effect.
- Zero-wait consumer (sync tied high): notify is high exactly one cycle per window. Throughput is one window per NUM_SAMPLES+1 cycles.
- count is ceil(log2(NUM_SAMPLES+1)) bits and never wraps, because it is cleared on every window end.

Optional Feature:
- Macro: MS_SLAVE_ACC_DROP_CNT_EN.
- Defined:
  - Adds output drop_cnt [15:0]. It increments once per cycle spent in SECTION_SEND, i.e. per discarded s_in sample.
  - Saturates at 16'hFFFF and is cleared only by rst.
  - It is a lifetime stall counter; windows do not reset it.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Package ms_slave_accumulator_types:
  - Sections enum {SECTION_IDLE, SECTION_SAMPLE, SECTION_SEND}.
  - SAT_MAX and SAT_MIN constants derived from DATA_W.
  - Shares scam_model_types conventions.
- Sub-module sat_add: combinational DATA_W-bit signed saturating adder with a clamp output. Instantiated once.
- FSM and registers stay in the top.

Test Plan:
- Reset then s_in = 1, 2, 3, 4 with sync = 1:
  - notify rises one cycle after the fourth sample, with b_out_sig = 10 and sat_flag = 0.
  - notify is high for exactly 1 cycle.
- s_in = 32'h7FFFFFF0 then 32'h20, 5, 5:
  - b_out_sig = 32'h7FFFFFFF, sat_flag = 1.
  - Next window s_in = -1 ×4 gives -4, sat_flag = 0.
- Backpressure: window of 7s (sum 28), sync low for 5 cycles:
  - notify and b_out_sig = 28 held for all 5 cycles.
  - The transfer occurs on the first sync edge.
  - The window after it excludes the samples from the stall cycles.
- rst asserted while in SEND with notify high:
  - The next cycle notify = 0 and b_out_sig = 0.
  - After release: one IDLE cycle, then a fresh 4-sample window.
- NUM_SAMPLES = 1, sync = 1, s_in = 5, 6, 7, 8…:
  - Outputs are 5, 7 (6 is dropped in SEND), alternating sample/send.
- MS_SLAVE_ACC_DROP_CNT_EN defined, 3-cycle stall plus handshake cycle:
  - drop_cnt = 4.
  - It saturates at 16'hFFFF under a forced long stall.
